// File: rtl/seq_control_unit.sv
// -----------------------------------------------------------------------------
// seq_control_unit
//
// Multicycle control unit for the register-file datapath. An instruction word
// is captured on a new_func strobe into the instruction register (IR). A Moore
// state machine (IDLE -> T1 -> T2 -> T3) then steps through the instruction.
// Every datapath enable is decoded combinationally from the registered state
// and the IR.
//
// Instruction word, FW = 3 + 2*RW + DW bits:
//   [FW-1 -: 3]  opcode  000 ADD, 001 SUB, 010 AND, 011 OR,
//                        100 MV, 101 MVI, 110 NOP, 111 illegal
//   [.. -: RW]   rx      destination / first operand register
//   [.. -: RW]   ry      source / second operand register
//   [DW-1:0]     imm     immediate, driven on `data`
//
// Parameters:
//   NREG   number of registers (>= 2), RW = $clog2(NREG)
//   DW     data / immediate width
//   QDEPTH instruction queue depth (power of 2, >= 2); queue build only
//
// Optional feature (compile-time macro CTRL_QUEUE_EN):
//   undefined : no queue. new_func is accepted only in IDLE, full = busy.
//   defined   : a QDEPTH-entry FIFO of instruction words. new_func is
//               accepted whenever full = 0. The next instruction is issued
//               straight out of the final step, with no idle cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   resetn    in   asynchronous active-low reset
//   new_func  in   instruction-valid strobe
//   func      in   [FW-1:0] instruction word
//   reg_in    out  [NREG-1:0] one-hot register write enable
//   reg_out   out  [NREG-1:0] one-hot register bus drive
//   A_in      out  latch bus into A
//   G_in      out  latch ALU result into G
//   G_out     out  drive G onto bus
//   data_in   out  drive `data` onto bus
//   op        out  [1:0] ALU select: 00 add, 01 sub, 10 and, 11 or
//   data      out  [DW-1:0] immediate field of the current instruction
//   state     out  [1:0] 00 IDLE, 01 T1, 10 T2, 11 T3
//   busy      out  state != IDLE
//   done      out  one-cycle pulse in the final step of an instruction
//   err       out  one-cycle pulse on an illegal instruction
//   full      out  a new instruction cannot be accepted
// -----------------------------------------------------------------------------
module seq_control_unit #(
    parameter int NREG   = 8,
    parameter int DW     = 16,
    parameter int QDEPTH = 4,
    localparam int RW    = $clog2(NREG),
    localparam int FW    = 3 + 2*RW + DW
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            new_func,
    input  logic [FW-1:0]   func,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_out,
    output logic            A_in,
    output logic            G_in,
    output logic            G_out,
    output logic            data_in,
    output logic [1:0]      op,
    output logic [DW-1:0]   data,
    output logic [1:0]      state,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            full
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_T1   = 2'b01,
        S_T2   = 2'b10,
        S_T3   = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MV  = 3'b100,
        OP_MVI = 3'b101,
        OP_NOP = 3'b110,
        OP_ILL = 3'b111
    } opcode_t;

    state_t          state_q;
    state_t          state_d;
    logic [FW-1:0]   ir_q;
    logic [FW-1:0]   ir_d;
    logic            issue;     // an instruction enters IR and T1 follows

    // -------------------------------------------------------------------------
    // IR field decode
    // -------------------------------------------------------------------------
    logic [2:0]      ir_opc;
    logic [RW-1:0]   ir_rx;
    logic [RW-1:0]   ir_ry;
    logic [DW-1:0]   ir_imm;
    logic            illegal;
    logic            is_alu;

    assign ir_opc = ir_q[FW-1 -: 3];
    assign ir_rx  = ir_q[FW-4 -: RW];
    assign ir_ry  = ir_q[DW +: RW];
    assign ir_imm = ir_q[DW-1:0];

    // Register fields can encode indices past NREG when NREG is not a power
    // of two. Those are treated exactly like the illegal opcode.
    assign illegal = (ir_opc == OP_ILL)
                  || (32'(ir_rx) >= NREG)
                  || (32'(ir_ry) >= NREG);

    // The four ALU opcodes share opcode[2] = 0 and take the three-step path.
    assign is_alu  = !illegal && (ir_opc[2] == 1'b0);

    // -------------------------------------------------------------------------
    // Instruction issue
    // -------------------------------------------------------------------------
`ifdef CTRL_QUEUE_EN
    localparam int QW = $clog2(QDEPTH);

    logic [FW-1:0]   q_mem [QDEPTH];
    logic [QW-1:0]   wr_ptr;
    logic [QW-1:0]   rd_ptr;
    logic [QW:0]     q_count;
    logic            q_empty;
    logic            last_step;
    logic            can_issue;
    logic            bypass;
    logic            push;
    logic            pop;

    assign q_empty   = (q_count == '0);
    assign full      = (q_count == (QW+1)'(QDEPTH));
    assign last_step = ((state_q == S_T1) && !is_alu) || (state_q == S_T3);
    assign can_issue = (state_q == S_IDLE) || last_step;

    // With an empty queue a fresh strobe goes straight into IR. This keeps the
    // one-cycle accept-to-T1 latency of the unqueued build.
    assign bypass    = can_issue && q_empty && new_func;
    assign pop       = can_issue && !q_empty;

    // A strobe while full is refused, even if a pop frees a slot in the same
    // cycle.
    assign push      = new_func && !full && !bypass;
    assign issue     = bypass || pop;
    assign ir_d      = pop ? q_mem[rd_ptr] : func;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            // Both pointers are QW bits wide, so they wrap modulo QDEPTH.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // NOTE: storage is left unreset. Emptying the queue only needs the
    // pointers and count cleared, and stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= func;
    end
`else
    // Without the queue a strobe is taken only in IDLE. A strobe while busy
    // is dropped.
    assign issue = (state_q == S_IDLE) && new_func;
    assign ir_d  = func;
    assign full  = busy;

    // QDEPTH sizes the queue only. This ties it off in the unqueued build.
    logic unused_qdepth;
    assign unused_qdepth = (QDEPTH != 0);
`endif

    // -------------------------------------------------------------------------
    // State and instruction registers
    // -------------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments, so every flop samples
    // pre-edge values regardless of the order of the always blocks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ir_q <= '0;
        end else if (issue) begin
            ir_q <= ir_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = issue ? S_T1 : S_IDLE;
            S_T1:    state_d = is_alu ? S_T2 : (issue ? S_T1 : S_IDLE);
            S_T2:    state_d = S_T3;
            S_T3:    state_d = issue ? S_T1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (Moore: state and IR only)
    // -------------------------------------------------------------------------
    logic [NREG-1:0] rx_hot;
    logic [NREG-1:0] ry_hot;

    assign rx_hot = NREG'(1) << ir_rx;
    assign ry_hot = NREG'(1) << ir_ry;

    always_comb begin
        // NOTE: every output gets a default first. Paths that leave an output
        // unassigned would otherwise infer a latch.
        reg_in  = '0;
        reg_out = '0;
        A_in    = 1'b0;
        G_in    = 1'b0;
        G_out   = 1'b0;
        data_in = 1'b0;
        op      = 2'b00;
        done    = 1'b0;
        err     = 1'b0;

        case (state_q)
            S_T1: begin
                if (illegal) begin
                    done = 1'b1;
                    err  = 1'b1;
                end else begin
                    case (ir_opc)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            reg_out = rx_hot;
                            A_in    = 1'b1;
                        end
                        OP_MV: begin
                            reg_out = ry_hot;
                            reg_in  = rx_hot;
                            done    = 1'b1;
                        end
                        OP_MVI: begin
                            data_in = 1'b1;
                            reg_in  = rx_hot;
                            done    = 1'b1;
                        end
                        default: begin  // NOP
                            done = 1'b1;
                        end
                    endcase
                end
            end
            S_T2: begin
                // Only ALU opcodes reach T2. The low two opcode bits are
                // exactly the ALU select.
                reg_out = ry_hot;
                G_in    = 1'b1;
                op      = ir_opc[1:0];
            end
            S_T3: begin
                G_out  = 1'b1;
                reg_in = rx_hot;
                done   = 1'b1;
            end
            default: ;  // IDLE: nothing asserted
        endcase
    end

    assign state = state_q;
    assign busy  = (state_q != S_IDLE);
    assign data  = ir_imm;

endmodule

// File: tb/tb_seq_control_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_control_unit
//
// Bench for seq_control_unit in its unqueued build, instantiated with NREG=6.
// With six registers, register fields 6 and 7 are out of range and must be
// treated as illegal.
//
// The driver issues directed instructions first, then random ones. At each
// accepted strobe, a reference model expands the instruction into the list of
// control steps it should produce and appends them to a scoreboard queue. The
// model follows the opcode table and tracks its own idle/busy time. A monitor
// samples the outputs on every falling edge:
//   - in reset, it expects all outputs to be zero;
//   - with the scoreboard empty, it expects IDLE outputs;
//   - otherwise, it pops the next expected step and compares.
// -----------------------------------------------------------------------------
module tb_seq_control_unit;

    localparam int NREG   = 6;
    localparam int DW     = 16;
    localparam int QDEPTH = 4;
    localparam int RW     = $clog2(NREG);
    localparam int FW     = 3 + 2*RW + DW;

    logic            clk = 1'b0;
    logic            resetn;
    logic            new_func;
    logic [FW-1:0]   func;
    logic [NREG-1:0] reg_in;
    logic [NREG-1:0] reg_out;
    logic            A_in;
    logic            G_in;
    logic            G_out;
    logic            data_in;
    logic [1:0]      op;
    logic [DW-1:0]   data;
    logic [1:0]      state;
    logic            busy;
    logic            done;
    logic            err;
    logic            full;

    seq_control_unit #(
        .NREG   (NREG),
        .DW     (DW),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .new_func (new_func),
        .func     (func),
        .reg_in   (reg_in),
        .reg_out  (reg_out),
        .A_in     (A_in),
        .G_in     (G_in),
        .G_out    (G_out),
        .data_in  (data_in),
        .op       (op),
        .data     (data),
        .state    (state),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .full     (full)
    );

    always #5 clk = ~clk;

    // One observable control step.
    typedef struct packed {
        logic [1:0]      st;
        logic [NREG-1:0] rin;
        logic [NREG-1:0] rout;
        logic            a_in;
        logic            g_in;
        logic            g_out;
        logic            d_in;
        logic [1:0]      op;
        logic [DW-1:0]   data;
        logic            done;
        logic            err;
        logic            busy;
        logic            full;
    } step_t;

    step_t         sb[$];
    int            checks   = 0;
    int            errors   = 0;
    int            rem      = 0;    // model: busy cycles still to come
    logic [DW-1:0] last_imm = '0;   // model: imm of the last accepted word

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic step_t observed();
        step_t s;
        s.st    = state;
        s.rin   = reg_in;
        s.rout  = reg_out;
        s.a_in  = A_in;
        s.g_in  = G_in;
        s.g_out = G_out;
        s.d_in  = data_in;
        s.op    = op;
        s.data  = data;
        s.done  = done;
        s.err   = err;
        s.busy  = busy;
        s.full  = full;
        return s;
    endfunction

    // A busy step: data carries the instruction immediate; busy and full set.
    function automatic step_t busy_step(input logic [1:0] st,
                                        input logic [DW-1:0] imm);
        step_t s;
        s      = '0;
        s.st   = st;
        s.data = imm;
        s.busy = 1'b1;
        s.full = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] alu_select(input logic [2:0] opc);
        case (opc)
            3'd0:    return 2'b00;  // ADD
            3'd1:    return 2'b01;  // SUB
            3'd2:    return 2'b10;  // AND
            default: return 2'b11;  // OR
        endcase
    endfunction

    // Reference model: expand one accepted instruction into its steps.
    task automatic expect_instr(input logic [FW-1:0] f);
        logic [2:0]    opc;
        int            rx;
        int            ry;
        logic [DW-1:0] imm;
        step_t         s1;
        step_t         s2;
        step_t         s3;
        opc = f[FW-1 -: 3];
        rx  = int'(f[FW-4 -: RW]);
        ry  = int'(f[DW +: RW]);
        imm = f[DW-1:0];
        last_imm = imm;
        s1 = busy_step(2'b01, imm);
        if (opc == 3'd7 || rx >= NREG || ry >= NREG) begin
            s1.done = 1'b1;
            s1.err  = 1'b1;
            sb.push_back(s1);
            rem = 1;
        end else if (opc < 3'd4) begin
            s1.rout[rx] = 1'b1;
            s1.a_in     = 1'b1;
            s2 = busy_step(2'b10, imm);
            s2.rout[ry] = 1'b1;
            s2.g_in     = 1'b1;
            s2.op       = alu_select(opc);
            s3 = busy_step(2'b11, imm);
            s3.g_out    = 1'b1;
            s3.rin[rx]  = 1'b1;
            s3.done     = 1'b1;
            sb.push_back(s1);
            sb.push_back(s2);
            sb.push_back(s3);
            rem = 3;
        end else begin
            if (opc == 3'd4) begin          // MV
                s1.rout[ry] = 1'b1;
                s1.rin[rx]  = 1'b1;
            end else if (opc == 3'd5) begin // MVI
                s1.d_in     = 1'b1;
                s1.rin[rx]  = 1'b1;
            end
            s1.done = 1'b1;
            sb.push_back(s1);
            rem = 1;
        end
    endtask

    // Model view of a clock edge.
    task automatic model_edge();
        if (resetn) begin
            if (rem == 0) begin
                if (new_func) expect_instr(func);
            end else begin
                rem--;
            end
        end
    endtask

    // Drive inputs for one cycle, let the model see the edge, step past it.
    task automatic tick(input logic nf, input logic [FW-1:0] f);
        new_func = nf;
        func     = f;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input int opc, input int rx,
                                         input int ry, input int imm);
        logic [FW-1:0] f;
        f = {3'(opc), RW'(rx), RW'(ry), DW'(imm)};
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_func();
        int rx;
        int ry;
        rx = ($urandom_range(0, 7) == 0) ? $urandom_range(NREG, (1 << RW) - 1)
                                         : $urandom_range(0, NREG - 1);
        ry = ($urandom_range(0, 7) == 0) ? $urandom_range(NREG, (1 << RW) - 1)
                                         : $urandom_range(0, NREG - 1);
        return mk($urandom_range(0, 7), rx, ry, $urandom_range(0, 65535));
    endfunction

    // Issue one instruction, then idle until the model says it is finished.
    task automatic run(input logic [FW-1:0] f);
        int guard;
        tick(1'b1, f);
        guard = 0;
        while (rem > 0 && guard < 8) begin
            tick(1'b0, rand_func());
            guard++;
        end
    endtask

    // Asynchronous reset pulse away from the active edge; the outputs must
    // clear before any further clock edge.
    task automatic pulse_reset();
        #2 resetn = 1'b0;
        #1 check("async_reset_outputs", 64'(observed()), 64'(0));
        sb.delete();
        rem      = 0;
        last_imm = '0;
        @(negedge clk);
        #1 resetn = 1'b1;
    endtask

    // Monitor: compare the DUT against the scoreboard on every falling edge.
    initial begin
        step_t act;
        step_t exp;
        forever begin
            @(negedge clk);
            act = observed();
            if (!resetn) begin
                check("reset_outputs", 64'(act), 64'(0));
            end else if (sb.size() == 0) begin
                exp      = '0;
                exp.data = last_imm;
                check("idle_outputs", 64'(act), 64'(exp));
            end else begin
                exp = sb.pop_front();
                check("control_step", 64'(act), 64'(exp));
            end
        end
    end

    initial begin
        int guard;

        // Reset held with new_func high: nothing may be accepted.
        resetn   = 1'b0;
        new_func = 1'b1;
        func     = mk(0, 1, 0, 16'h000F);
        repeat (3) @(posedge clk);
        #1 new_func = 1'b0;
        @(negedge clk);
        #1 resetn = 1'b1;
        repeat (3) tick(1'b0, rand_func());   // IDLE held without a strobe

        // Directed instructions, issued back to back.
        run(mk(0, 1, 0, 16'h000F));           // ADD R1,R0
        run(mk(5, 3, 0, 16'h00A5));           // MVI R3,#00A5
        run(mk(1, 2, 3, 16'h1234));           // SUB R2,R3
        run(mk(2, 5, 4, 16'hFFFF));           // AND R5,R4
        run(mk(3, 0, 5, 16'h8001));           // OR  R0,R5
        run(mk(4, 4, 1, 16'h0042));           // MV  R4,R1
        run(mk(6, 0, 0, 16'h5A5A));           // NOP
        run(mk(7, 1, 2, 16'h0BAD));           // illegal opcode
        run(mk(4, 7, 1, 16'h0007));           // MV with rx out of range
        run(mk(0, 2, 6, 16'h0006));           // ADD with ry out of range
        run(mk(0, 5, 5, 16'h0000));           // ADD, highest legal register

        // Strobes while busy are dropped.
        tick(1'b1, mk(0, 1, 2, 16'h1111));
        tick(1'b1, mk(4, 0, 1, 16'h2222));
        tick(1'b1, mk(5, 2, 0, 16'h3333));
        tick(1'b1, mk(6, 0, 0, 16'h4444));
        tick(1'b1, mk(5, 4, 0, 16'h5555));    // accepted: ADD has finished
        tick(1'b0, rand_func());
        tick(1'b0, rand_func());

        // Reset in T2 of an ADD: abandoned, then normal operation resumes.
        tick(1'b1, mk(0, 3, 4, 16'h7777));
        tick(1'b0, rand_func());              // DUT now in T2
        pulse_reset();
        run(mk(4, 0, 5, 16'h0A0A));
        run(mk(1, 4, 2, 16'hC0DE));

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else tick($urandom_range(0, 1) == 1, rand_func());
        end

        // Drain: nothing expected may be left over.
        guard = 0;
        while (rem > 0 && guard < 8) begin
            tick(1'b0, rand_func());
            guard++;
        end
        tick(1'b0, rand_func());
        tick(1'b0, rand_func());
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
